result_uart_streamer: RTL and testbench

Parametrised successor to the fixed single-byte systolic-array UART dump. Captures one multi-channel result vector from the array output via valid/ready. Serialises it as a framed 8N1 UART packet: sync byte, per-channel little-endian payload, then an XOR checksum. Runs on the system clock with an internal baud-tick counter, so no derived clocks are needed.

---
 rtl/result_uart_streamer.sv | 75 +++++++
 tb/tb_result_uart_streamer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/result_uart_streamer.sv
// result_uart_streamer: captures one multi-channel result vector and sends it as a framed 8N1 UART packet (sync, payload, XOR checksum)
module result_uart_streamer #(
    parameter int          CLKS_PER_BIT = 1250,
    parameter int          NUM_CH       = 4,
    parameter int          DATA_W       = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_count
);
    localparam int BPW    = (DATA_W + 7) / 8;
    localparam int PAY    = NUM_CH * BPW;
    localparam int NBYTES = PAY + 2;
    localparam int IW     = $clog2(NBYTES);
    localparam int BW     = $clog2(CLKS_PER_BIT);
    typedef enum logic {IDLE, SEND} state_t;
    state_t              state_q, state_d;
    logic [NBYTES*8-1:0] frame_q;
    logic [PAY*8-1:0]    pad_in;
    logic [7:0]          chk_in;
    logic [IW-1:0]       byte_q;
    logic [3:0]          bit_q;
    logic [BW-1:0]       baud_q;
    logic                bit_end, byte_end, capture;
    always_comb begin
        pad_in = '0;
        for (int c = 0; c < NUM_CH; c++) pad_in[c*BPW*8 +: DATA_W] = in_data[c*DATA_W +: DATA_W];
    end
    always_comb begin
        chk_in = '0;
        for (int i = 0; i < PAY; i++) chk_in = chk_in ^ pad_in[i*8 +: 8];
    end
    assign in_ready = state_q == IDLE;
    assign busy     = ~in_ready;
    assign capture  = in_valid & in_ready;
    assign bit_end  = baud_q == BW'(CLKS_PER_BIT - 1);
    assign byte_end = bit_end && bit_q == 4'd9;
    // bit_q: 0 = start, 1..8 = data (LSB sits at frame_q[0]), 9 = stop
    assign tx = (state_q == IDLE) || bit_q == 4'd9 || (bit_q != 4'd0 && frame_q[0]);
    always_comb begin
        frame_done = state_q == SEND && byte_end && byte_q == IW'(NBYTES - 1);
        state_d    = (state_q == IDLE) ? (in_valid ? SEND : IDLE) : (frame_done ? IDLE : SEND);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            byte_q      <= '0;
            bit_q       <= '0;
            baud_q      <= '0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            frame_count <= frame_count + 16'(frame_done);
            if (capture) begin
                frame_q <= {chk_in, pad_in, SYNC_BYTE};
                byte_q  <= '0;
                bit_q   <= '0;
                baud_q  <= '0;
            end else if (state_q == SEND) begin
                baud_q <= bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) bit_q <= byte_end ? 4'd0 : bit_q + 4'd1;
                if (bit_end && bit_q != 4'd0 && bit_q != 4'd9) frame_q <= frame_q >> 1;
                if (byte_end) byte_q <= byte_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_result_uart_streamer.sv
// tb_result_uart_streamer: directed UART-decode bench for result_uart_streamer (CLKS_PER_BIT=4, NUM_CH=2, DATA_W=12)
module tb_result_uart_streamer;
    localparam int CPB = 4;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, tx, busy, frame_done;
    logic [15:0] frame_count;
    int          cyc = 0, done_cyc = 0, done_n = 0, vec = 0, errs = 0;
    int          f0, fb, bad;
    logic [7:0]  b;

    result_uart_streamer #(.CLKS_PER_BIT(CPB), .NUM_CH(2), .DATA_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx(tx), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_done) begin done_cyc = cyc; done_n++; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples each bit in its middle; returns the cycle of the first low start-bit sample.
    task automatic get_byte(output logic [7:0] d, output int fall);
        int n = 0;
        d = '0;
        fall = -1;
        while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (tx !== 1'b0) begin check("start_timeout", 1, 0); return; end
        fall = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); d[i] = tx; end
        repeat (CPB) @(negedge clk);
        check("stop_bit", {31'b0, tx}, 1);
    endtask

    task automatic get_frame(input logic [47:0] exp, input string tag, output int first);
        logic [7:0] d;
        int f;
        first = -1;
        for (int k = 0; k < 6; k++) begin
            get_byte(d, f);
            if (k == 0) first = f;
            check($sformatf("%s_byte%0d", tag, k), {24'b0, d}, {24'b0, exp[k*8 +: 8]});
        end
    endtask

    initial begin
        #1;
        check("rst_tx", {31'b0, tx}, 1);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_frame_done", {31'b0, frame_done}, 0);
        check("rst_frame_count", {16'b0, frame_count}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || in_ready !== 1'b1 || frame_count !== 16'd0) bad++;
        end
        check("idle_100", bad, 0);

        // single pulse frame: ch0=123, ch1=ABC
        in_data = {12'hABC, 12'h123};
        in_valid = 1'b1;
        get_frame(48'h94_0A_BC_01_23_A5, "f1", f0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("f1_len", done_cyc - f0 + 1, 240);
        check("f1_done_n", done_n, 1);
        check("f1_count", {16'b0, frame_count}, 1);
        check("f1_ready", {31'b0, in_ready}, 1);
        repeat (5) @(negedge clk);
        check("f1_no_refire", done_n, 1);

        // three back-to-back frames with in_valid held high
        in_data = {12'h800, 12'h0FF};
        in_valid = 1'b1;
        get_frame(48'hF7_08_00_00_FF_A5, "b2b1", f0);
        in_data = {12'h001, 12'hF0F};
        get_frame(48'h01_00_01_0F_0F_A5, "b2b2", fb);
        check("gap12", fb - done_cyc, 2);
        in_data = {12'hAAA, 12'h555};
        get_frame(48'hF0_0A_AA_05_55_A5, "b2b3", fb);
        check("gap23", fb - done_cyc, 2);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_len", done_cyc - fb + 1, 240);
        check("b2b_done_n", done_n, 4);
        check("b2b_count", {16'b0, frame_count}, 4);

        // asynchronous reset during the third data byte
        in_data = {12'h800, 12'h0FF};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) get_byte(b, fb);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_tx_low", {31'b0, tx}, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'b0, tx}, 1);
        check("async_rst_ready", {31'b0, in_ready}, 1);
        check("async_rst_count", {16'b0, frame_count}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, in_ready}, 1);
        check("post_rst_tx", {31'b0, tx}, 1);
        in_data = {12'hAAA, 12'h555};
        in_valid = 1'b1;
        get_frame(48'hF0_0A_AA_05_55_A5, "after_rst", f0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("after_rst_count", {16'b0, frame_count}, 1);

        // frame_count wrap from 16'hFFFF
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        in_data = {12'h001, 12'hF0F};
        in_valid = 1'b1;
        get_frame(48'h01_00_01_0F_0F_A5, "wrap", f0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_count", {16'b0, frame_count}, 0);
        check("wrap_done_n", done_n, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
